// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory request/response, decode handoff and execute redirect.
interface instr_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [6:0]  opcode_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o, opcode_o,
    input  instr_ready_i,
    input  redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o, opcode_o,
    output instr_ready_i,
    output redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front end: word-aligned PC generation, one outstanding imem request, DEPTH-entry {instr,pc} FIFO to decode.
// 1-cycle memory gives request N -> data N+1 -> decode N+2; fetch stalls while the FIFO could not absorb the next response.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {RUN, PEND, DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifoEntry_t;

  state_t        state;
  logic [31:0]   fetchPc;
  logic [31:0]   tagPc;
  fifoEntry_t    fifoMem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [CW:0]   countAfter;
  logic          headValid;
  logic          pop;
  logic          push;
  logic          canIssue;
  logic          issue;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign headValid  = (count != '0);
  assign pop        = headValid && bus.instr_ready_i;
  assign push       = (state == PEND) && bus.imem_rvalid_i && !bus.redirect_i;
  assign countAfter = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign canIssue   = (state == RUN) || ((state == PEND) && bus.imem_rvalid_i);
  // Only issue when the FIFO keeps a free slot for this request's response.
  assign issue      = rst_i && !bus.redirect_i && canIssue && (countAfter < DEPTH_W);

  assign bus.imem_req_o    = issue;
  assign bus.imem_addr_o   = fetchPc;
  assign bus.instr_valid_o = headValid;
  assign bus.instr_o       = headValid ? fifoMem[rdPtr].instr : 32'h0;
  assign bus.instr_pc_o    = headValid ? fifoMem[rdPtr].pc : 32'h0;
  assign bus.opcode_o      = bus.instr_o[6:0];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem[wrPtr] <= {bus.imem_rdata_i, tagPc};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= RUN;
      fetchPc <= RESET_PC;
      tagPc   <= RESET_PC;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
    end else if (bus.redirect_i) begin
      fetchPc <= {bus.redirect_pc_i[31:2], 2'b00};
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      // A response still in flight belongs to the old path and must be swallowed.
      state   <= ((state != RUN) && !bus.imem_rvalid_i) ? DROP : RUN;
    end else begin
      if (push) wrPtr <= ptrInc(wrPtr);
      if (pop)  rdPtr <= ptrInc(rdPtr);
      count <= countAfter[CW-1:0];
      if (issue) begin
        fetchPc <= fetchPc + 32'd4;
        tagPc   <= fetchPc;
      end
      case (state)
        RUN:     if (issue) state <= PEND;
        PEND:    if (bus.imem_rvalid_i) state <= issue ? PEND : RUN;
        DROP:    if (bus.imem_rvalid_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle tables, directed redirect/reset sequences and a random run checked
// against a queue-based reference model; a second instance covers the PC wrap at 32'hFFFF_FFFC.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN0;
  logic rstN1;
  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus1();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rstN0), .bus(bus)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dutWrap (
    .clk_i(clk), .rst_i(rstN1), .bus(bus1)
  );

  int total = 0;
  int bad = 0;
  int cycN = 0;
  int memDue = -1;
  logic [31:0] memAddr = 32'h0;
  int minLat = 1;
  int maxLat = 1;
  bit stray = 1'b0;

  logic        obsReq, obsValid;
  logic [31:0] obsAddr, obsInstr, obsPc;
  logic [6:0]  obsOp;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        mQ[$];
  logic [31:0] mPc, mTag;
  bit          mOut, mStale;

  typedef struct {
    bit          first;
    bit          ready;
    bit          expReq;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;
  vec_t vecs[12];

  logic        wReq   [4];
  logic [31:0] wAddr  [4];
  logic        wValid [4];
  logic [31:0] wPc    [4];
  logic [31:0] wInstr [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cycN, act, exp);
    end
  endtask

  // Reference: queue of delivered words plus "request in flight" and "in-flight is stale" flags.
  task automatic modelStep();
    bit   v, pop, respOk, issue;
    int   after;
    ent_t e;
    v = (mQ.size() != 0);
    chk("valid", 32'(obsValid), 32'(v));
    chk("instr", obsInstr, v ? mQ[0].instr : 32'h0);
    chk("pc", obsPc, v ? mQ[0].pc : 32'h0);
    chk("opcode", 32'(obsOp), v ? 32'(mQ[0].instr[6:0]) : 32'h0);
    pop    = v && bus.instr_ready_i;
    respOk = mOut && !mStale && bus.imem_rvalid_i && !bus.redirect_i;
    after  = mQ.size() + int'(respOk) - int'(pop);
    issue  = !bus.redirect_i && (!mOut || (!mStale && bus.imem_rvalid_i)) && (after < DEPTH);
    chk("req", 32'(obsReq), 32'(issue));
    if (issue) chk("addr", obsAddr, mPc);
    if (bus.redirect_i) begin
      mQ.delete();
      mPc    = {bus.redirect_pc_i[31:2], 2'b00};
      mStale = mOut && !bus.imem_rvalid_i;
      mOut   = mStale;
    end else begin
      if (pop) void'(mQ.pop_front());
      if (respOk) begin
        e.instr = bus.imem_rdata_i;
        e.pc    = mTag;
        mQ.push_back(e);
      end
      if (bus.imem_rvalid_i) begin
        mOut   = 1'b0;
        mStale = 1'b0;
      end
      if (issue) begin
        mTag = mPc;
        mPc  = mPc + 32'd4;
        mOut = 1'b1;
      end
    end
  endtask

  // One clock cycle: memory responder drives the response, outputs sampled at the falling edge.
  task automatic cyc();
    bit due;
    due = (memDue == cycN);
    bus.imem_rvalid_i = due || stray;
    bus.imem_rdata_i  = due ? memAddr + 32'h13 : 32'hDEAD_BEEF;
    @(negedge clk);
    obsReq   = bus.imem_req_o;
    obsAddr  = bus.imem_addr_o;
    obsValid = bus.instr_valid_o;
    obsInstr = bus.instr_o;
    obsPc    = bus.instr_pc_o;
    obsOp    = bus.opcode_o;
    modelStep();
    if (obsReq === 1'b1) begin
      memAddr = obsAddr;
      memDue  = cycN + int'($urandom_range(maxLat, minLat));
    end
    @(posedge clk);
    #1;
    cycN++;
    stray = 1'b0;
  endtask

  task automatic doReset();
    rstN0 = 1'b0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    memDue = -1;
    #1;
    chk("rst req", 32'(bus.imem_req_o), 32'h0);
    chk("rst addr", bus.imem_addr_o, 32'h0);
    chk("rst valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rst instr", bus.instr_o, 32'h0);
    chk("rst pc", bus.instr_pc_o, 32'h0);
    chk("rst opcode", 32'(bus.opcode_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    mQ.delete();
    mPc = 32'h0; mTag = 32'h0; mOut = 1'b0; mStale = 1'b0;
    rstN0 = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found, sawValid;
    rstN0 = 1'b0;
    rstN1 = 1'b0;
    bus1.instr_ready_i = 1'b0; bus1.redirect_i = 1'b0; bus1.redirect_pc_i = 32'h0;
    bus1.imem_rvalid_i = 1'b0; bus1.imem_rdata_i = 32'h0;

    // 1-cycle memory returning addr+0x13; first rows: free-running, then decode stalled for 4 cycles.
    vecs[0]  = '{1, 1, 1, 32'h00, 0, 32'h0, 32'h0};
    vecs[1]  = '{0, 1, 1, 32'h04, 0, 32'h0, 32'h0};
    vecs[2]  = '{0, 1, 1, 32'h08, 1, 32'h0, 32'h13};
    vecs[3]  = '{0, 1, 1, 32'h0C, 1, 32'h4, 32'h17};
    vecs[4]  = '{0, 1, 1, 32'h10, 1, 32'h8, 32'h1B};
    vecs[5]  = '{1, 0, 1, 32'h00, 0, 32'h0, 32'h0};
    vecs[6]  = '{0, 0, 1, 32'h04, 0, 32'h0, 32'h0};
    vecs[7]  = '{0, 0, 0, 32'h08, 1, 32'h0, 32'h13};
    vecs[8]  = '{0, 0, 0, 32'h08, 1, 32'h0, 32'h13};
    vecs[9]  = '{0, 1, 1, 32'h08, 1, 32'h0, 32'h13};
    vecs[10] = '{0, 1, 1, 32'h0C, 1, 32'h4, 32'h17};
    vecs[11] = '{0, 1, 1, 32'h10, 1, 32'h8, 32'h1B};

    minLat = 1; maxLat = 1;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].first) doReset();
      bus.instr_ready_i = vecs[i].ready;
      cyc();
      chk($sformatf("tbl%0d req", i), 32'(obsReq), 32'(vecs[i].expReq));
      if (vecs[i].expReq) chk($sformatf("tbl%0d addr", i), obsAddr, vecs[i].expAddr);
      chk($sformatf("tbl%0d valid", i), 32'(obsValid), 32'(vecs[i].expValid));
      chk($sformatf("tbl%0d pc", i), obsPc, vecs[i].expPc);
      chk($sformatf("tbl%0d instr", i), obsInstr, vecs[i].expInstr);
      chk($sformatf("tbl%0d opcode", i), 32'(obsOp), 32'(vecs[i].expInstr[6:0]));
    end

    // Redirect while the pc-8 fetch is outstanding on 3-cycle memory.
    doReset();
    minLat = 3; maxLat = 3;
    bus.instr_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (obsReq === 1'b1 && obsAddr == 32'h8) found = 1'b1;
    end
    chk("drop reach pc8", 32'(found), 32'h1);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
    cyc();
    bus.redirect_i = 1'b0;
    chk("drop req on redirect", 32'(obsReq), 32'h0);
    found = 1'b0; sawValid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (obsValid === 1'b1) sawValid = 1'b1;
      if (obsReq === 1'b1) found = 1'b1;
    end
    chk("drop refetch seen", 32'(found), 32'h1);
    chk("drop refetch addr", obsAddr, 32'h100);
    chk("drop fifo empty", 32'(sawValid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (obsValid === 1'b1) found = 1'b1;
    end
    chk("drop first delivery", 32'(found), 32'h1);
    chk("drop first pc", obsPc, 32'h100);
    chk("drop first instr", obsInstr, 32'h113);

    // Redirect to an unaligned target in the same cycle as the response: no DROP.
    doReset();
    minLat = 1; maxLat = 1;
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h103;
    cyc();
    bus.redirect_i = 1'b0;
    chk("coinc req on redirect", 32'(obsReq), 32'h0);
    cyc();
    chk("coinc refetch req", 32'(obsReq), 32'h1);
    chk("coinc refetch addr", obsAddr, 32'h100);
    chk("coinc empty", 32'(obsValid), 32'h0);
    cyc();
    cyc();
    chk("coinc deliver valid", 32'(obsValid), 32'h1);
    chk("coinc deliver pc", obsPc, 32'h100);
    chk("coinc deliver instr", obsInstr, 32'h113);

    // Reset while a fetch is pending with an entry buffered; stray response right after release.
    doReset();
    minLat = 3; maxLat = 3;
    repeat (5) cyc();
    chk("midpend buffered", 32'(obsValid), 32'h1);
    doReset();
    stray = 1'b1;
    cyc();
    chk("midpend first req", 32'(obsReq), 32'h1);
    chk("midpend first addr", obsAddr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (obsValid === 1'b1) found = 1'b1;
    end
    chk("midpend delivery", 32'(found), 32'h1);
    chk("midpend pc", obsPc, 32'h0);
    chk("midpend instr", obsInstr, 32'h13);

    // Random traffic: variable latency, stalls, redirects, occasional resets.
    doReset();
    minLat = 1; maxLat = 3;
    for (int i = 0; i < 800; i++) begin
      if (i % 250 == 249) doReset();
      bus.instr_ready_i = ($urandom_range(9, 0) < 7);
      bus.redirect_i    = ($urandom_range(15, 0) == 0);
      bus.redirect_pc_i = $urandom;
      cyc();
    end
    bus.redirect_i = 1'b0;

    // PC wrap on the second instance.
    #1;
    chk("wrap rst addr", bus1.imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap rst req", 32'(bus1.imem_req_o), 32'h0);
    rstN1 = 1'b1;
    bus1.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wReq[i]   = bus1.imem_req_o;
      wAddr[i]  = bus1.imem_addr_o;
      wValid[i] = bus1.instr_valid_o;
      wPc[i]    = bus1.instr_pc_o;
      wInstr[i] = bus1.instr_o;
      @(posedge clk);
      #1;
      bus1.imem_rvalid_i = wReq[i];
      bus1.imem_rdata_i  = wAddr[i] + 32'h13;
    end
    chk("wrap req0", 32'(wReq[0]), 32'h1);
    chk("wrap addr0", wAddr[0], 32'hFFFF_FFFC);
    chk("wrap req1", 32'(wReq[1]), 32'h1);
    chk("wrap addr1", wAddr[1], 32'h0000_0000);
    chk("wrap valid2", 32'(wValid[2]), 32'h1);
    chk("wrap pc2", wPc[2], 32'hFFFF_FFFC);
    chk("wrap instr2", wInstr[2], 32'h0000_000F);
    chk("wrap pc3", wPc[3], 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
